// File: rtl/rom_dump_uart_tx.sv
// Buffers ROM-reader bytes in a FIFO and streams them out as 8N1 UART frames.
// Optional: define ROM_DUMP_CHECKSUM_EN to append a two's-complement checksum frame after each block.
`timescale 1ns/1ps
module rom_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef ROM_DUMP_CHECKSUM_EN
  localparam int EW = 9;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CHK} state_t;
`else
  localparam int EW = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_n;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   wr_entry, head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count, count_n;
  logic            full_r, push, pop, empty;
  logic [15:0]     baud_cnt;
  logic            baud_done;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            tx_n;

`ifdef ROM_DUMP_CHECKSUM_EN
  logic [7:0]      sum;
  logic            last_r, is_chk;
  assign wr_entry = {in_last, in_data};
`else
  logic            unused_last;
  assign unused_last = in_last;
  assign wr_entry    = in_data;
`endif

  assign empty      = (count == '0);
  assign in_ready   = ~full_r;
  assign push       = in_valid & ~full_r;
  assign pop        = (state == IDLE) & ~empty;
  assign head       = mem[rd_ptr];
  assign fifo_level = count;
  assign baud_done  = (baud_cnt == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (!push && pop) count_n = count - 1'b1;
  end

  // tx is registered from the state, so the line lags the FSM by one cycle
  always_comb begin
    state_n = state;
    tx_n    = 1'b1;
    case (state)
      IDLE:  if (!empty) state_n = START;
      START: begin
        tx_n = 1'b0;
        if (baud_done) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg[0];
        if (baud_done && bit_cnt == 3'd7) state_n = STOP;
      end
      STOP: if (baud_done) begin
`ifdef ROM_DUMP_CHECKSUM_EN
        state_n = (last_r && !is_chk) ? CHK : IDLE;
`else
        state_n = IDLE;
`endif
      end
`ifdef ROM_DUMP_CHECKSUM_EN
      CHK:   state_n = START;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      full_r   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
`ifdef ROM_DUMP_CHECKSUM_EN
      sum      <= '0;
      last_r   <= 1'b0;
      is_chk   <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      count  <= count_n;
      full_r <= (count_n == LW'(FIFO_DEPTH));
      tx     <= tx_n;
      busy   <= (state != IDLE) || !empty;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (in_valid && full_r) overflow <= 1'b1;
      if (state == START || state == DATA || state == STOP)
        baud_cnt <= baud_done ? '0 : baud_cnt + 16'd1;
      else
        baud_cnt <= '0;
      if (pop)                            bit_cnt <= '0;
      else if (state == DATA && baud_done) bit_cnt <= bit_cnt + 3'd1;
`ifdef ROM_DUMP_CHECKSUM_EN
      if (pop) begin
        sum    <= sum + head[7:0];
        last_r <= head[8];
        is_chk <= 1'b0;
      end else if (state == CHK) begin
        sum    <= '0;
        is_chk <= 1'b1;
      end
`endif
    end
  end

  // FIFO storage and shifter carry data only and need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
    if (pop)
      shreg <= head[7:0];
`ifdef ROM_DUMP_CHECKSUM_EN
    else if (state == CHK)
      shreg <= ~sum + 8'd1;
`endif
    else if (state == DATA && baud_done)
      shreg <= shreg >> 1;
  end
endmodule

// File: tb/tb_rom_dump_uart_tx.sv
// Directed testbench for rom_dump_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
`timescale 1ns/1ps
module tb_rom_dump_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, tx, busy, overflow;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp;   // line bits in time order: bit0 = start, bit9 = stop
  } vec_t;
  vec_t vecs[5];

  always #50 clk = ~clk;

  rom_dump_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .tx(tx), .busy(busy),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_start(input int limit, output int waited, output bit found);
    waited = 0;
    found  = 1'b0;
    while (waited < limit && !found) begin
      @(negedge clk);
      waited++;
      if (tx === 1'b0) found = 1'b1;
    end
  endtask

  // Entered on the first low sample of a start bit; leaves on the last stop sample.
  task automatic read_frame(output logic [9:0] pat, output bit held);
    held = 1'b1;
    pat  = '0;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (c == 0) pat[b] = tx;
        else if (tx !== pat[b]) held = 1'b0;
      end
  endtask

  task automatic collect(input int idle_limit);
    int w;
    bit f;
    logic [9:0] pat;
    bit held;
    f = 1'b1;
    while (f) begin
      wait_start(idle_limit, w, f);
      if (f) begin
        read_frame(pat, held);
        rxq.push_back(pat[8:1]);
        chk("frame_shape", {29'd0, held, pat[9], pat[0]}, 32'b110);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    bit f;
    logic [9:0] pat;
    bit held;
    in_data  = v.data;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("vec_lvl_push", fifo_level, 1);
    chk("vec_tx_edge1", tx, 1);
    @(negedge clk);
    chk("vec_tx_edge2", tx, 1);
    chk("vec_lvl_pop", fifo_level, 0);
    wait_start(10, w, f);
    chk("vec_latency", w, 1);
    if (f) begin
      read_frame(pat, held);
      chk("vec_frame", pat, v.exp);
      chk("vec_held", held, 1);
      chk("vec_busy_stop", busy, 1);
      @(negedge clk);
      chk("vec_busy_idle", busy, 0);
      chk("vec_tx_idle", tx, 1);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit f;
    bit stayed;
    logic [9:0] pat;
    bit held;
    logic [7:0] exp_blk1[$];
    logic [7:0] exp_blk2[$];

    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};
`ifdef ROM_DUMP_CHECKSUM_EN
    exp_blk1 = '{8'h01, 8'h02, 8'h03, 8'hFA};
    exp_blk2 = '{8'h10, 8'hF0};
`else
    exp_blk1 = '{8'h01, 8'h02, 8'h03};
    exp_blk2 = '{8'h10};
`endif

    // reset values
    #5 reset = 1'b0;
    #10;
    chk("rst_tx", tx, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_lvl", fifo_level, 0);
    #65 reset = 1'b1;
    @(negedge clk);

    // single-byte frames from the vector table
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // back-to-back frames
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_lvl_push1", fifo_level, 1);
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_lvl_after_pop1", fifo_level, 1);
    wait_start(10, w, f);
    chk("b2b_latency", w, 1);
    read_frame(pat, held);
    chk("b2b_frame1", pat, 10'b1_00000000_0);
    chk("b2b_held1", held, 1);
    @(negedge clk);
    chk("b2b_gap_tx", tx, 1);
    chk("b2b_lvl_after_pop2", fifo_level, 0);
    wait_start(10, w, f);
    chk("b2b_gap_len", w, 1);
    read_frame(pat, held);
    chk("b2b_frame2", pat, 10'b1_11111111_0);
    chk("b2b_held2", held, 1);
    @(negedge clk);
    chk("b2b_busy_idle", busy, 0);

    // overflow: 20 strobes into a 1 + 16 byte pipeline
    rxq.delete();
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          if (k == 16) chk("ovf_ready_s17", in_ready, 1);
          if (k == 17) begin
            chk("ovf_ready_s18", in_ready, 0);
            chk("ovf_flag_before", overflow, 0);
          end
          in_data  = k[7:0];
          in_valid = 1'b1;
          @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ovf_flag_set", overflow, 1);
        chk("ovf_lvl_full", fifo_level, 16);
      end
      collect(100);
    join
    chk("ovf_frame_count", rxq.size(), 17);
    foreach (rxq[i]) chk("ovf_frame_data", rxq[i], i);
    chk("ovf_lvl_drained", fifo_level, 0);
    chk("ovf_flag_sticky", overflow, 1);

    // asynchronous reset mid-frame with bytes queued
    for (int k = 0; k < 6; k++) begin
      in_data  = 8'h20 + k[7:0];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("arst_lvl_queued", fifo_level, 5);
    repeat (9) @(negedge clk);
    chk("arst_tx_low_before", tx, 0);
    #10 reset = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_lvl", fifo_level, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_ovf", overflow, 0);
    #9 reset = 1'b1;
    stayed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) stayed = 1'b0;
    end
    chk("arst_stays_idle", stayed, 1);
    chk("arst_lvl_after", fifo_level, 0);

    // dump blocks with in_last
    rxq.delete();
    fork
      begin
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b1);
      end
      collect(100);
    join
    chk("blk1_count", rxq.size(), exp_blk1.size());
    for (int i = 0; i < exp_blk1.size() && i < rxq.size(); i++)
      chk("blk1_data", rxq[i], exp_blk1[i]);

    rxq.delete();
    fork
      push_byte(8'h10, 1'b1);
      collect(100);
    join
    chk("blk2_count", rxq.size(), exp_blk2.size());
    for (int i = 0; i < exp_blk2.size() && i < rxq.size(); i++)
      chk("blk2_data", rxq[i], exp_blk2[i]);
    chk("blk2_busy_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
